// File: rtl/ras_ctrl.sv
// ras_ctrl: sequencer between the fetch/decode front end and the return
// address stack. It turns accepted call/return/branch requests and in-order
// branch resolutions into stack strobes. It keeps the checkpoint count within
// MAX_BRANCHES and holds a two-cycle settle window after every close_valid.
// Popped addresses are returned one cycle after the pop.
// Optional build macro RAS_CTRL_STATS_EN adds saturating event counters.
module ras_ctrl #(
  parameter int WIDTH        = 32,
  parameter int MAX_BRANCHES = 16,
  parameter int CNT_W        = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_push,
  input  logic             req_pop,
  input  logic             req_branch,
  input  logic [WIDTH-1:0] req_data,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic             res_mispredict,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_empty,
  output logic             ras_push,
  output logic             ras_pop,
  output logic             ras_branch,
  output logic             ras_close_valid,
  output logic             ras_close_invalid,
  output logic [WIDTH-1:0] ras_din,
  input  logic [WIDTH-1:0] ras_dout,
  input  logic             ras_empty,
  output logic [CNT_W-1:0] outstanding
`ifdef RAS_CTRL_STATS_EN
  ,
  output logic [31:0]      stat_empty_pops,
  output logic [31:0]      stat_mispredicts,
  output logic [31:0]      stat_branch_stalls
`endif
);

  typedef enum logic [1:0] {RUN, SETTLE1, SETTLE2, FLUSH} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BRANCHES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             rsp_valid_q;
  logic             rsp_empty_q;

  logic             res_acc, mis_acc, ok_acc;
  logic             req_acc, branch_acc, branch_block, branch_stall;

  // Handshakes and stack strobes; reset forces every strobe low immediately
  always_comb begin
    res_ready         = !reset && (state_q == RUN) && (outstanding_q != '0);
    res_acc           = res_valid && res_ready;
    mis_acc           = res_acc && res_mispredict;
    ok_acc            = res_acc && !res_mispredict;
    // A branch at capacity is only allowed when a checkpoint closes this cycle
    branch_block      = req_branch && (outstanding_q == MAX_CNT) && !ok_acc;
    req_ready         = !reset && (state_q != FLUSH) && !mis_acc && !branch_block;
    req_acc           = req_valid && req_ready;
    branch_acc        = req_acc && req_branch;
    branch_stall      = req_valid && !reset && (state_q != FLUSH) && !mis_acc && branch_block;
    ras_push          = req_acc && req_push;
    ras_pop           = req_acc && req_pop;
    ras_branch        = branch_acc;
    ras_din           = ras_push ? req_data : '0;
    ras_close_valid   = ok_acc;
    ras_close_invalid = mis_acc;
  end

  // Next state and outstanding-branch count
  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q;
    unique case (state_q)
      SETTLE1: state_d = SETTLE2;
      SETTLE2: state_d = RUN;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
    if (mis_acc) begin
      state_d       = FLUSH;
      outstanding_d = '0;
    end else begin
      if (ok_acc) state_d = SETTLE1;
      if (branch_acc && !ok_acc && (outstanding_q != MAX_CNT))
        outstanding_d = outstanding_q + CNT_W'(1);
      else if (ok_acc && !branch_acc && (outstanding_q != '0))
        outstanding_d = outstanding_q - CNT_W'(1);
    end
  end

  // Registered state, pop response and optional statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= RUN;
      outstanding_q      <= '0;
      rsp_valid_q        <= 1'b0;
      rsp_empty_q        <= 1'b0;
`ifdef RAS_CTRL_STATS_EN
      stat_empty_pops    <= '0;
      stat_mispredicts   <= '0;
      stat_branch_stalls <= '0;
`endif
    end else begin
      state_q            <= state_d;
      outstanding_q      <= outstanding_d;
      rsp_valid_q        <= ras_pop;
      rsp_empty_q        <= ras_pop && ras_empty;
`ifdef RAS_CTRL_STATS_EN
      if (ras_pop && ras_empty && (stat_empty_pops != '1))
        stat_empty_pops <= stat_empty_pops + 32'd1;
      if (mis_acc && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + 32'd1;
      if (branch_stall && (stat_branch_stalls != '1))
        stat_branch_stalls <= stat_branch_stalls + 32'd1;
`endif
    end
  end

`ifndef RAS_CTRL_STATS_EN
  logic unused_stall;
  assign unused_stall = branch_stall;
`endif

  assign rsp_valid   = rsp_valid_q;
  assign rsp_empty   = rsp_empty_q;
  assign rsp_data    = rsp_valid_q ? ras_dout : '0;
  assign outstanding = outstanding_q;

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl: inputs change on the falling edge, outputs are
// checked 1 ns later, so each check sees one cycle's combinational strobes
// and the state registered at the preceding rising edge.
module tb_ras_ctrl;
  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready, req_push, req_pop, req_branch;
  logic [WIDTH-1:0] req_data;
  logic             res_valid, res_ready, res_mispredict;
  logic             rsp_valid, rsp_empty;
  logic [WIDTH-1:0] rsp_data;
  logic             ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid;
  logic [WIDTH-1:0] ras_din, ras_dout;
  logic             ras_empty;
  logic [CNT_W-1:0] outstanding;
`ifdef RAS_CTRL_STATS_EN
  logic [31:0]      stat_empty_pops, stat_mispredicts, stat_branch_stalls;
`endif

  int errors = 0;
  int checks = 0;

  ras_ctrl #(.WIDTH(WIDTH), .MAX_BRANCHES(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_push(req_push),
    .req_pop(req_pop), .req_branch(req_branch), .req_data(req_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_mispredict(res_mispredict),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_empty(rsp_empty),
    .ras_push(ras_push), .ras_pop(ras_pop), .ras_branch(ras_branch),
    .ras_close_valid(ras_close_valid), .ras_close_invalid(ras_close_invalid),
    .ras_din(ras_din), .ras_dout(ras_dout), .ras_empty(ras_empty),
    .outstanding(outstanding)
`ifdef RAS_CTRL_STATS_EN
    ,
    .stat_empty_pops(stat_empty_pops), .stat_mispredicts(stat_mispredicts),
    .stat_branch_stalls(stat_branch_stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and return all request inputs to idle
  task automatic nx();
    @(negedge clk);
    req_valid = 1'b0; req_push = 1'b0; req_pop = 1'b0; req_branch = 1'b0;
    req_data = '0; res_valid = 1'b0; res_mispredict = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b1; req_push = 1'b1; req_pop = 1'b0; req_branch = 1'b0;
    req_data = 32'h1234; res_valid = 1'b0; res_mispredict = 1'b0;
    ras_dout = '0; ras_empty = 1'b0;

    // Reset: everything low even with a request presented
    #7;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_ras_push", ras_push, 0);
    chk("rst_ras_din", ras_din, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_res_ready", res_ready, 0);
    nx();
    nx(); reset = 1'b0;

    // Push 0x100, push 0x200, pop, pop, pop
    req_valid = 1; req_push = 1; req_data = 32'h100; #1;
    chk("t1_ready0", req_ready, 1);
    chk("t1_push0", ras_push, 1);
    chk("t1_din0", ras_din, 32'h100);
    nx(); req_valid = 1; req_push = 1; req_data = 32'h200; #1;
    chk("t1_push1", ras_push, 1);
    chk("t1_din1", ras_din, 32'h200);
    chk("t1_rspv_early", rsp_valid, 0);
    nx(); req_valid = 1; req_pop = 1; ras_empty = 0; #1;
    chk("t1_pop0", ras_pop, 1);
    chk("t1_push_none", ras_push, 0);
    nx(); req_valid = 1; req_pop = 1; ras_empty = 0; ras_dout = 32'h200; #1;
    chk("t1_rspv0", rsp_valid, 1);
    chk("t1_rspd0", rsp_data, 32'h200);
    chk("t1_rspe0", rsp_empty, 0);
    nx(); req_valid = 1; req_pop = 1; ras_empty = 1; ras_dout = 32'h100; #1;
    chk("t1_rspv1", rsp_valid, 1);
    chk("t1_rspd1", rsp_data, 32'h100);
    chk("t1_rspe1", rsp_empty, 0);
    nx(); ras_empty = 0; ras_dout = '0; #1;
    chk("t1_rspv2", rsp_valid, 1);
    chk("t1_rspe2", rsp_empty, 1);
    nx(); #1;
    chk("t1_rspv_done", rsp_valid, 0);

    // Fill the checkpoint FIFO with 16 branches
    for (int i = 0; i < 16; i++) begin
      if (i != 0) nx();
      req_valid = 1; req_branch = 1; #1;
      chk($sformatf("t2_br%0d", i), ras_branch, 1);
    end
    // 17th branch stalls for three cycles
    for (int i = 0; i < 3; i++) begin
      nx(); req_valid = 1; req_branch = 1; #1;
      chk($sformatf("t2_full_out%0d", i), outstanding, 16);
      chk($sformatf("t2_stall_rdy%0d", i), req_ready, 0);
      chk($sformatf("t2_stall_br%0d", i), ras_branch, 0);
    end
    // Branch and correct resolution together at capacity (cycle N)
    nx(); req_valid = 1; req_branch = 1; res_valid = 1; #1;
    chk("t2_pair_rdy", req_ready, 1);
    chk("t2_pair_br", ras_branch, 1);
    chk("t2_pair_resrdy", res_ready, 1);
    chk("t2_pair_cv", ras_close_valid, 1);
    // N+1 and N+2: settle window blocks resolutions
    nx(); res_valid = 1; req_valid = 1; req_push = 1; req_data = 32'h33; #1;
    chk("t3_out_kept", outstanding, 16);
    chk("t3_rr_n1", res_ready, 0);
    chk("t3_cv_n1", ras_close_valid, 0);
    chk("t3_push_settle", ras_push, 1);
    nx(); res_valid = 1; #1;
    chk("t3_rr_n2", res_ready, 0);
    chk("t3_cv_n2", ras_close_valid, 0);
    nx(); res_valid = 1; #1;
    chk("t3_rr_n3", res_ready, 1);
    chk("t3_cv_n3", ras_close_valid, 1);
    nx(); nx(); nx(); #1;
    chk("t3_out15", outstanding, 15);
    chk("t3_run_rr", res_ready, 1);

    // Mispredict with a same-cycle push
    res_valid = 1; res_mispredict = 1; req_valid = 1; req_push = 1; req_data = 32'h55; #1;
    chk("t4_ci", ras_close_invalid, 1);
    chk("t4_cv", ras_close_valid, 0);
    chk("t4_push", ras_push, 0);
    chk("t4_rdy", req_ready, 0);
    nx(); req_valid = 1; req_push = 1; req_data = 32'h66; #1;
    chk("t4_out0", outstanding, 0);
    chk("t4_flush_rdy", req_ready, 0);
    chk("t4_flush_push", ras_push, 0);
    chk("t4_flush_rr", res_ready, 0);
    nx(); req_valid = 1; req_push = 1; req_data = 32'h77; #1;
    chk("t4_run_push", ras_push, 1);
    chk("t4_run_din", ras_din, 32'h77);

    // Second empty pop
    nx(); req_valid = 1; req_pop = 1; ras_empty = 1; #1;
    chk("t5_pop", ras_pop, 1);
    nx(); ras_empty = 0; #1;
    chk("t5_rspv", rsp_valid, 1);
    chk("t5_rspe", rsp_empty, 1);
`ifdef RAS_CTRL_STATS_EN
    chk("st_empty", stat_empty_pops, 2);
    chk("st_mis", stat_mispredicts, 1);
    chk("st_stall", stat_branch_stalls, 3);
`endif

    // Asynchronous reset between a pop and its response
    nx(); req_valid = 1; req_branch = 1; #1;
    chk("t6_br0", ras_branch, 1);
    nx(); req_valid = 1; req_branch = 1;
    nx(); req_valid = 1; req_pop = 1; #1;
    chk("t6_out2", outstanding, 2);
    chk("t6_pop", ras_pop, 1);
    #1; reset = 1'b1; #1;
    chk("t6_rst_pop", ras_pop, 0);
    chk("t6_rst_rdy", req_ready, 0);
    chk("t6_rst_out", outstanding, 0);
    chk("t6_rst_rspv", rsp_valid, 0);
    nx(); #1;
    chk("t6_rspv_held", rsp_valid, 0);
    nx(); reset = 1'b0; #1;
    chk("t6_post_rspv", rsp_valid, 0);
    chk("t6_post_rdy", req_ready, 1);
    chk("t6_post_out", outstanding, 0);
`ifdef RAS_CTRL_STATS_EN
    chk("t6_st_empty", stat_empty_pops, 0);
    chk("t6_st_mis", stat_mispredicts, 0);
    chk("t6_st_stall", stat_branch_stalls, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
